// File: rtl/mouse_event_fifo.sv
// Turns PS/2 mouse state into press/release/move events queued in a DEPTH-entry FIFO.
// Optional build macro MOUSE_MOVE_COALESCE_EN merges a new move into a trailing move entry.
module mouse_event_fifo #(
  parameter int COORD_W = 16,
  parameter int DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [COORD_W-1:0]         x_addr,
  input  logic [COORD_W-1:0]         y_addr,
  input  logic                       LBM,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [1:0]                 ev_type,
  output logic [COORD_W-1:0]         ev_x,
  output logic [COORD_W-1:0]         ev_y,
  output logic [$clog2(DEPTH):0]     ev_count,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  localparam logic [1:0] T_NONE  = 2'b00;
  localparam logic [1:0] T_PRESS = 2'b01;
  localparam logic [1:0] T_REL   = 2'b10;
  localparam logic [1:0] T_MOVE  = 2'b11;

  typedef struct packed {
    logic [1:0]         typ;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } ev_t;

  // Handshake: an entry leaves the FIFO on any cycle where ev_valid and ev_ready are both 1.
  logic [COORD_W-1:0] prev_x_q, prev_x_d;
  logic [COORD_W-1:0] prev_y_q, prev_y_d;
  logic               prev_lbm_q, prev_lbm_d;
  logic               primed_q, primed_d;
  ev_t                pend_q, pend_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               overflow_q, overflow_d;
  ev_t                mem_q [DEPTH];

  logic               push, pop, full, coalesce, wr_en, drop, mem_we;
  logic [AW-1:0]      tail_idx, mem_idx;
  logic [1:0]         det_typ;
  ev_t                head;

  always_comb begin
    det_typ = T_NONE;
    if (primed_q) begin
      if (LBM && !prev_lbm_q)                               det_typ = T_PRESS;
      else if (!LBM && prev_lbm_q)                          det_typ = T_REL;
      else if ((x_addr != prev_x_q) || (y_addr != prev_y_q)) det_typ = T_MOVE;
    end
    pend_d     = '{typ: det_typ, x: x_addr, y: y_addr};
    prev_x_d   = x_addr;
    prev_y_d   = y_addr;
    prev_lbm_d = LBM;
    primed_d   = 1'b1;

    push     = (pend_q.typ != T_NONE);
    pop      = (count_q != '0) && ev_ready;
    full     = (count_q == FULL_CNT);
    tail_idx = wr_ptr_q - AW'(1);
`ifdef MOUSE_MOVE_COALESCE_EN
    // Only merge when the tail survives this cycle: a lone entry being popped is not a target.
    coalesce = push && (pend_q.typ == T_MOVE) && (count_q != '0) &&
               (mem_q[tail_idx].typ == T_MOVE) && ((count_q > ONE_CNT) || !pop);
`else
    coalesce = 1'b0;
`endif
    wr_en   = push && !coalesce && (!full || pop);
    drop    = push && !coalesce && full && !pop;
    mem_we  = wr_en || coalesce;
    mem_idx = coalesce ? tail_idx : wr_ptr_q;

    wr_ptr_d = wr_ptr_q + (wr_en ? AW'(1) : AW'(0));
    rd_ptr_d = rd_ptr_q + (pop ? AW'(1) : AW'(0));
    count_d  = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
    // Drop beats clear so a loss in the clearing cycle is never hidden.
    overflow_d = (overflow_q && !ovf_clr) || drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_x_q   <= '0;
      prev_y_q   <= '0;
      prev_lbm_q <= 1'b0;
      primed_q   <= 1'b0;
      pend_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      prev_x_q   <= prev_x_d;
      prev_y_q   <= prev_y_d;
      prev_lbm_q <= prev_lbm_d;
      primed_q   <= primed_d;
      pend_q     <= pend_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[mem_idx] <= pend_q;
  end

  assign head     = mem_q[rd_ptr_q];
  assign ev_valid = (count_q != '0);
  assign ev_type  = ev_valid ? head.typ : T_NONE;
  assign ev_x     = head.x;
  assign ev_y     = head.y;
  assign ev_count = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_mouse_event_fifo.sv
// Bench for mouse_event_fifo: directed vector table, corner-case sequences and a random run
// checked against a queue-based event model.
module tb_mouse_event_fifo;
  localparam int CW = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] x_addr = '0, y_addr = '0;
  logic          LBM = 1'b0, ev_ready = 1'b0, ovf_clr = 1'b0;
  logic          ev_valid, overflow;
  logic [1:0]    ev_type;
  logic [CW-1:0] ev_x, ev_y;
  logic [3:0]    ev_count;

  int errors = 0;
  int checks = 0;

  mouse_event_fifo #(.COORD_W(CW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .x_addr(x_addr), .y_addr(y_addr), .LBM(LBM),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type), .ev_x(ev_x), .ev_y(ev_y),
    .ev_count(ev_count), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of events plus the previous-sample and pending-event state.
  typedef struct { logic [1:0] t; logic [CW-1:0] x; logic [CW-1:0] y; } mev_t;
  mev_t          mq[$];
  mev_t          m_pe;
  logic          m_pv, m_ovf, m_primed, m_pl;
  logic [CW-1:0] m_px, m_py;

  task automatic model_step(input logic r, input logic [CW-1:0] xi, input logic [CW-1:0] yi,
                            input logic li, input logic ri, input logic ci);
    logic pop, drop, do_push, done;
    if (r) begin
      mq.delete();
      m_ovf = 0; m_primed = 0; m_pl = 0; m_px = 0; m_py = 0; m_pv = 0;
    end else begin
      pop = (mq.size() != 0) && ri;
      drop = 0; do_push = 0; done = 0;
      if (m_pv) begin
`ifdef MOUSE_MOVE_COALESCE_EN
        if (m_pe.t == 2'b11 && mq.size() > 0 && mq[mq.size()-1].t == 2'b11 &&
            !(mq.size() == 1 && pop)) begin
          mq[mq.size()-1].x = m_pe.x;
          mq[mq.size()-1].y = m_pe.y;
          done = 1;
        end
`endif
        if (!done) begin
          if (mq.size() == DEPTH && !pop) drop = 1;
          else do_push = 1;
        end
      end
      if (pop) void'(mq.pop_front());
      if (do_push) mq.push_back(m_pe);
      m_ovf = (m_ovf && !ci) || drop;
      m_pv = 0;
      if (m_primed) begin
        if (li != m_pl) begin m_pv = 1; m_pe.t = li ? 2'b01 : 2'b10; end
        else if (xi != m_px || yi != m_py) begin m_pv = 1; m_pe.t = 2'b11; end
        m_pe.x = xi; m_pe.y = yi;
      end
      m_px = xi; m_py = yi; m_pl = li; m_primed = 1;
    end
  endtask

  // Drive one cycle's inputs, advance the model, then sample 1 time unit after the edge.
  task automatic cyc(input logic r, input logic [CW-1:0] xi, input logic [CW-1:0] yi,
                     input logic li, input logic ri, input logic ci);
    rst = r; x_addr = xi; y_addr = yi; LBM = li; ev_ready = ri; ovf_clr = ci;
    model_step(r, xi, yi, li, ri, ci);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("rnd_valid", int'(ev_valid), int'(mq.size() != 0));
    chk("rnd_count", int'(ev_count), mq.size());
    chk("rnd_ovf", int'(overflow), int'(m_ovf));
    if (mq.size() != 0) begin
      chk("rnd_type", int'(ev_type), int'(mq[0].t));
      chk("rnd_x", int'(ev_x), int'(mq[0].x));
      chk("rnd_y", int'(ev_y), int'(mq[0].y));
    end else begin
      chk("rnd_type_empty", int'(ev_type), 0);
    end
  endtask

  typedef struct {
    logic r; logic [CW-1:0] x; logic [CW-1:0] y; logic l; logic rdy; logic clr;
    logic e_valid; logic [1:0] e_type; logic [CW-1:0] e_x; logic [CW-1:0] e_y;
    logic [3:0] e_cnt; logic e_ovf;
  } vec_t;
  vec_t vecs[9];

  initial begin
    logic lb;
    logic [CW-1:0] rx, ry;
    int hi;

    //          r  x   y   l rdy clr | val typ  x   y  cnt ovf
    vecs[0] = '{1, 0,  0,  0, 0, 0,    0,  0,  0,  0,  0, 0};
    vecs[1] = '{0, 10, 20, 0, 0, 0,    0,  0,  0,  0,  0, 0};
    vecs[2] = '{0, 10, 20, 1, 0, 0,    0,  0,  0,  0,  0, 0};
    vecs[3] = '{0, 10, 20, 1, 0, 0,    1,  1, 10, 20,  1, 0};
    vecs[4] = '{0, 11, 20, 0, 0, 0,    1,  1, 10, 20,  1, 0};
    vecs[5] = '{0, 11, 20, 0, 0, 0,    1,  1, 10, 20,  2, 0};
    vecs[6] = '{0, 11, 20, 0, 1, 0,    1,  2, 11, 20,  1, 0};
    vecs[7] = '{0, 11, 20, 0, 1, 0,    0,  0,  0,  0,  0, 0};
    vecs[8] = '{0, 11, 20, 0, 1, 0,    0,  0,  0,  0,  0, 0};

    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin
      cyc(vecs[i].r, vecs[i].x, vecs[i].y, vecs[i].l, vecs[i].rdy, vecs[i].clr);
      chk($sformatf("vec%0d_valid", i), int'(ev_valid), int'(vecs[i].e_valid));
      chk($sformatf("vec%0d_type", i), int'(ev_type), int'(vecs[i].e_type));
      chk($sformatf("vec%0d_count", i), int'(ev_count), int'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_ovf", i), int'(overflow), int'(vecs[i].e_ovf));
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_x", i), int'(ev_x), int'(vecs[i].e_x));
        chk($sformatf("vec%0d_y", i), int'(ev_y), int'(vecs[i].e_y));
      end
    end

    // Fill past full, drop with a simultaneous clear, then push while popping at full.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    lb = 0;
    for (int i = 0; i < 9; i++) begin
      lb = ~lb;
      cyc(0, CW'(i), 0, lb, 0, 0);
    end
    chk("fill_count8", int'(ev_count), 8);
    chk("fill_no_ovf_yet", int'(overflow), 0);
    cyc(0, 8, 0, lb, 0, 1);
    chk("drop_count", int'(ev_count), 8);
    chk("drop_set_wins", int'(overflow), 1);
    cyc(0, 8, 0, lb, 0, 1);
    chk("ovf_clr", int'(overflow), 0);
    chk("ovf_clr_count", int'(ev_count), 8);
    chk("full_head_x", int'(ev_x), 0);
    lb = ~lb;
    cyc(0, 100, 0, lb, 0, 0);
    cyc(0, 100, 0, lb, 1, 0);
    chk("pushpop_full_count", int'(ev_count), 8);
    chk("pushpop_full_ovf", int'(overflow), 0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d_x", k), int'(ev_x), (k < 7) ? k + 1 : 100);
      chk($sformatf("drain%0d_type", k), int'(ev_type), (k < 7) ? (((k + 1) % 2 == 0) ? 1 : 2) : 2);
      cyc(0, 100, 0, lb, 1, 0);
    end
    chk("drained_count", int'(ev_count), 0);

    // Three consecutive moves into an empty FIFO.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 4, 5, 0, 0, 0);
    cyc(0, 5, 5, 0, 0, 0);
    cyc(0, 6, 5, 0, 0, 0);
    cyc(0, 7, 5, 0, 0, 0);
    cyc(0, 7, 5, 0, 0, 0);
    cyc(0, 7, 5, 0, 0, 0);
`ifdef MOUSE_MOVE_COALESCE_EN
    chk("coal_count", int'(ev_count), 1);
    chk("coal_type", int'(ev_type), 3);
    chk("coal_x", int'(ev_x), 7);
    chk("coal_y", int'(ev_y), 5);
`else
    chk("moves_count", int'(ev_count), 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("move%0d_type", k), int'(ev_type), 3);
      chk($sformatf("move%0d_x", k), int'(ev_x), 5 + k);
      cyc(0, 7, 5, 0, 1, 0);
    end
    chk("moves_drained", int'(ev_count), 0);
`endif

    // Reset with entries and a pending event, then the priming cycle must swallow a change.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    lb = 0;
    for (int i = 0; i < 5; i++) begin
      lb = ~lb;
      cyc(0, 0, 0, lb, 0, 0);
    end
    chk("pre_rst_count", int'(ev_count), 4);
    cyc(1, 0, 0, lb, 1, 1);
    chk("rst_count", int'(ev_count), 0);
    chk("rst_valid", int'(ev_valid), 0);
    chk("rst_type", int'(ev_type), 0);
    chk("rst_ovf", int'(overflow), 0);
    cyc(0, 99, 7, ~lb, 0, 0);
    cyc(0, 99, 7, ~lb, 0, 0);
    cyc(0, 99, 7, ~lb, 0, 0);
    chk("prime_no_event", int'(ev_count), 0);

    // Randomized run against the model.
    cyc(1, 0, 0, 0, 0, 0);
    rx = 0; ry = 0; lb = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) rx = CW'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) ry = CW'($urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) lb = ~lb;
      hi = ((n / 400) % 2 == 0) ? 1 : 6;
      cyc(($urandom_range(0, 299) == 0), rx, ry, lb,
          ($urandom_range(0, 7) < hi), ($urandom_range(0, 15) == 0));
      chk_model();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
